agen_unit: RTL and testbench

- Address-generation execution unit; sits directly downstream of the agen issue selector.
- Consumes one registered one-hot issue vector per cycle and selects that IQ entry's base and immediate operands.
- Computes the effective address and checks alignment.
- Presents the result to the memory queue with a valid/ready handshake.
- Drives `idle` back to the issue selector (that selector's agen0_idle/agen1_idle input), so two instances form agen0 and agen1.

---
 rtl/agen_unit_pkg.sv | 42 ++++
 rtl/agen_unit_if.sv | 34 +++
 rtl/agen_unit_onehot_to_qid.sv | 21 ++
 rtl/agen_unit.sv | 156 +++++++++++++++
 tb/tb_agen_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/agen_unit_pkg.sv
// Shared types for the agen execution unit: FSM states, access-size and exception codes.
package agen_unit_pkg;

  localparam int AGEN_IQ_ENTRIES = 8;
  localparam int AGEN_QID_W      = 3;
  localparam int AGEN_AW         = 52;

  typedef logic [AGEN_QID_W-1:0] qid_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } agen_state_t;

  typedef enum logic [1:0] {
    MEMSZ_BYTE  = 2'd0,
    MEMSZ_WYDE  = 2'd1,
    MEMSZ_TETRA = 2'd2,
    MEMSZ_OCTA  = 2'd3
  } memsz_t;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_MISALIGN = 2'd1,
    EXC_BOUNDS   = 2'd2
  } agen_exc_t;

  // Only the low three address bits matter for sizes up to an octa.
  function automatic logic is_misaligned(input logic [2:0] addr_lo, input memsz_t sz);
    logic mis;
    case (sz)
      MEMSZ_BYTE:  mis = 1'b0;
      MEMSZ_WYDE:  mis = addr_lo[0];
      MEMSZ_TETRA: mis = |addr_lo[1:0];
      MEMSZ_OCTA:  mis = |addr_lo[2:0];
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/agen_unit_if.sv
// Issue-queue operand bus and memory-queue result handshake of one agen unit.
interface agen_unit_if
  import agen_unit_pkg::*;
#(
  parameter int IQ_ENTRIES = AGEN_IQ_ENTRIES,
  parameter int QID_W      = AGEN_QID_W,
  parameter int AW         = AGEN_AW
) ();

  logic [IQ_ENTRIES-1:0]    issue;
  logic [IQ_ENTRIES*AW-1:0] iq_base;
  logic [IQ_ENTRIES*AW-1:0] iq_imm;
  logic [IQ_ENTRIES*2-1:0]  iq_memsz;
  logic [IQ_ENTRIES-1:0]    iq_store;
  logic                     idle;
  logic                     out_valid;
  logic                     out_ready;
  logic [QID_W-1:0]         out_qid;
  logic [AW-1:0]            out_addr;
  logic                     out_store;
  logic [1:0]               out_exc;
  logic                     multi_err;

  modport slave (
    input  issue, iq_base, iq_imm, iq_memsz, iq_store, out_ready,
    output idle, out_valid, out_qid, out_addr, out_store, out_exc, multi_err
  );

  modport master (
    output issue, iq_base, iq_imm, iq_memsz, iq_store, out_ready,
    input  idle, out_valid, out_qid, out_addr, out_store, out_exc, multi_err
  );

endinterface

// File: rtl/agen_unit_onehot_to_qid.sv
// One-hot to index encoder with lowest-index priority and a multi-hot flag.
module onehot_to_qid #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] onehot_i,
  output logic [W-1:0] qid_o,
  output logic         multi_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    qid_o = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      qid_o = onehot_i[i] ? W'(i) : qid_o;
    end
  end

  assign multi_o = |(onehot_i & (onehot_i - {{(N-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/agen_unit.sv
// Address-generation unit: issue capture, EA add, alignment check, valid/ready result.
// Optional bounds check against a limit port when AGEN_BOUNDS_CHECK_EN is defined.
module agen_unit
  import agen_unit_pkg::*;
#(
  parameter int IQ_ENTRIES = AGEN_IQ_ENTRIES,
  parameter int QID_W      = AGEN_QID_W,
  parameter int AW         = AGEN_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
`ifdef AGEN_BOUNDS_CHECK_EN
  input  logic [AW-1:0] limit,
`endif
  agen_unit_if.slave    bus
);

  agen_state_t      state_q, state_d;
  logic [QID_W-1:0] qid_q, qid_d;
  logic [AW-1:0]    base_q, base_d;
  logic [AW-1:0]    imm_q, imm_d;
  memsz_t           memsz_q, memsz_d;
  logic             store_q, store_d;
  logic             out_valid_q, out_valid_d;
  logic [QID_W-1:0] out_qid_q, out_qid_d;
  logic [AW-1:0]    out_addr_q, out_addr_d;
  logic             out_store_q, out_store_d;
  agen_exc_t        out_exc_q, out_exc_d;
  logic             multi_err_q, multi_err_d;

  logic [QID_W-1:0] sel_qid_s;
  logic             sel_multi_s;
  logic [AW-1:0]    addr_s;
  agen_exc_t        exc_s;

  onehot_to_qid #(.N(IQ_ENTRIES), .W(QID_W)) u_onehot_to_qid (
    .onehot_i (bus.issue),
    .qid_o    (sel_qid_s),
    .multi_o  (sel_multi_s)
  );

  assign addr_s = base_q + imm_q;

  // Bounds outranks misalignment when the limit check is built in.
  always_comb begin
    exc_s = EXC_NONE;
`ifdef AGEN_BOUNDS_CHECK_EN
    if (addr_s > limit) begin
      exc_s = EXC_BOUNDS;
    end else if (is_misaligned(addr_s[2:0], memsz_q)) begin
      exc_s = EXC_MISALIGN;
    end else begin
      exc_s = EXC_NONE;
    end
`else
    if (is_misaligned(addr_s[2:0], memsz_q)) begin
      exc_s = EXC_MISALIGN;
    end else begin
      exc_s = EXC_NONE;
    end
`endif
  end

  // Next-state and datapath loads for the IDLE -> CALC -> HOLD sequence.
  always_comb begin
    state_d     = state_q;
    qid_d       = qid_q;
    base_d      = base_q;
    imm_d       = imm_q;
    memsz_d     = memsz_q;
    store_d     = store_q;
    out_valid_d = out_valid_q;
    out_qid_d   = out_qid_q;
    out_addr_d  = out_addr_q;
    out_store_d = out_store_q;
    out_exc_d   = out_exc_q;
    multi_err_d = multi_err_q;
    case (state_q)
      IDLE: begin
        if (bus.issue != {IQ_ENTRIES{1'b0}}) begin
          qid_d       = sel_qid_s;
          base_d      = bus.iq_base[int'(sel_qid_s)*AW +: AW];
          imm_d       = bus.iq_imm[int'(sel_qid_s)*AW +: AW];
          memsz_d     = memsz_t'(bus.iq_memsz[int'(sel_qid_s)*2 +: 2]);
          store_d     = bus.iq_store[sel_qid_s];
          multi_err_d = multi_err_q | sel_multi_s;
          state_d     = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        out_qid_d   = qid_q;
        out_addr_d  = addr_s;
        out_store_d = store_q;
        out_exc_d   = exc_s;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and result registers; reset wins over the clock enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      qid_q       <= {QID_W{1'b0}};
      base_q      <= {AW{1'b0}};
      imm_q       <= {AW{1'b0}};
      memsz_q     <= MEMSZ_BYTE;
      store_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_qid_q   <= {QID_W{1'b0}};
      out_addr_q  <= {AW{1'b0}};
      out_store_q <= 1'b0;
      out_exc_q   <= EXC_NONE;
      multi_err_q <= 1'b0;
    end else if (ce) begin
      state_q     <= state_d;
      qid_q       <= qid_d;
      base_q      <= base_d;
      imm_q       <= imm_d;
      memsz_q     <= memsz_d;
      store_q     <= store_d;
      out_valid_q <= out_valid_d;
      out_qid_q   <= out_qid_d;
      out_addr_q  <= out_addr_d;
      out_store_q <= out_store_d;
      out_exc_q   <= out_exc_d;
      multi_err_q <= multi_err_d;
    end
  end

  assign bus.idle      = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_qid   = out_qid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_store = out_store_q;
  assign bus.out_exc   = out_exc_q;
  assign bus.multi_err = multi_err_q;

endmodule

// File: tb/tb_agen_unit.sv
// Scoreboard bench for agen_unit: expected results queued at issue, compared at out_valid.
module tb_agen_unit;
  import agen_unit_pkg::*;

  localparam int N  = 8;
  localparam int QW = 3;
  localparam int AW = 52;

  typedef struct packed {
    logic [QW-1:0] qid;
    logic [AW-1:0] addr;
    logic          store;
    logic [1:0]    exc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic ce;
`ifdef AGEN_BOUNDS_CHECK_EN
  logic [AW-1:0] limit;
`endif

  always #5 clk = ~clk;

  agen_unit_if #(.IQ_ENTRIES(N), .QID_W(QW), .AW(AW)) bus ();

  agen_unit #(.IQ_ENTRIES(N), .QID_W(QW), .AW(AW)) dut (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
`ifdef AGEN_BOUNDS_CHECK_EN
    .limit (limit),
`endif
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t last_obs;
  exp_t last_exp;

  function automatic logic [1:0] model_exc(input logic [AW-1:0] a, input logic [1:0] sz);
    logic [AW-1:0] mask;
    logic [1:0]    e;
    mask = (52'd1 << sz) - 52'd1;
    e = ((a & mask) != 52'd0) ? 2'd1 : 2'd0;
`ifdef AGEN_BOUNDS_CHECK_EN
    if (a > limit) e = 2'd2;
`endif
    return e;
  endfunction

  task automatic set_entry(input int idx, input logic [AW-1:0] b, input logic [AW-1:0] im,
                           input logic [1:0] sz, input logic st);
    bus.iq_base[idx*AW +: AW] = b;
    bus.iq_imm[idx*AW +: AW]  = im;
    bus.iq_memsz[idx*2 +: 2]  = sz;
    bus.iq_store[idx]         = st;
  endtask

  // Drive one issue vector for a cycle; returns at the negedge of cycle N+1.
  task automatic issue_op(input logic [N-1:0] oh);
    exp_t e;
    int   idx;
    idx = -1;
    for (int i = N - 1; i >= 0; i--) if (oh[i]) idx = i;
    checks++;
    if (bus.idle !== 1'b1) begin
      errors++;
      $display("FAIL issue_while_busy: idle=%b required 1", bus.idle);
    end
    e.qid   = QW'(idx);
    e.addr  = bus.iq_base[idx*AW +: AW] + bus.iq_imm[idx*AW +: AW];
    e.store = bus.iq_store[idx];
    e.exc   = model_exc(e.addr, bus.iq_memsz[idx*2 +: 2]);
    sb.push_back(e);
    bus.issue = oh;
    @(negedge clk);
    bus.issue = '0;
  endtask

  task automatic check_result(input string name);
    exp_t o;
    o = {bus.out_qid, bus.out_addr, bus.out_store, bus.out_exc};
    last_obs = o;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: result qid=%0d addr=%h with no expected entry", name, o.qid, o.addr);
    end else begin
      last_exp = sb.pop_front();
      if (o !== last_exp) begin
        errors++;
        $display("FAIL %s: got qid=%0d addr=%h st=%b exc=%0d, required qid=%0d addr=%h st=%b exc=%0d",
                 name, o.qid, o.addr, o.store, o.exc,
                 last_exp.qid, last_exp.addr, last_exp.store, last_exp.exc);
      end
    end
  endtask

  task automatic wait_valid(input int max, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      if (bus.out_valid === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, bus.out_valid, max);
    end
  endtask

  // Full op with out_ready high; ends one cycle after the handshake.
  task automatic run_op(input logic [N-1:0] oh, input string name);
    bit ok;
    bus.out_ready = 1'b1;
    issue_op(oh);
    wait_valid(4, name, ok);
    if (ok) check_result(name);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.idle, bus.out_qid, bus.out_addr, bus.out_store, bus.out_exc, bus.multi_err}
        !== {1'b0, 1'b1, 3'd0, 52'd0, 1'b0, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: valid=%b idle=%b qid=%0d addr=%h st=%b exc=%0d merr=%b, required 0 1 0 0 0 0 0",
               bus.out_valid, bus.idle, bus.out_qid, bus.out_addr, bus.out_store, bus.out_exc, bus.multi_err);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    set_entry(2, 52'h1000, 52'h20, 2'd3, 1'b0);
    bus.out_ready = 1'b1;
    issue_op(8'b0000_0100);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_n1: out_valid=%b required 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.idle} !== 2'b10) begin
      errors++; $display("FAIL basic_n2: valid,idle=%b required 10", {bus.out_valid, bus.idle});
    end
    check_result("basic");
    checks++;
    if (last_obs.addr !== 52'h1020 || last_obs.qid !== 3'd2) begin
      errors++; $display("FAIL basic_const: addr=%h qid=%0d required 1020 2", last_obs.addr, last_obs.qid);
    end
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.idle} !== 2'b01) begin
      errors++; $display("FAIL basic_n3: valid,idle=%b required 01", {bus.out_valid, bus.idle});
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    set_entry(4, 52'h2000_0000, 52'h48, 2'd2, 1'b1);
    bus.out_ready = 1'b0;
    issue_op(8'b0001_0000);
    wait_valid(4, "bp", ok);
    if (ok) check_result("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.idle, bus.out_addr} !== {1'b1, 1'b0, last_exp.addr}) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b idle=%b addr=%h, required 1 0 %h",
                 i, bus.out_valid, bus.idle, bus.out_addr, last_exp.addr);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.idle} !== 2'b01) begin
      errors++; $display("FAIL bp_release: valid,idle=%b required 01", {bus.out_valid, bus.idle});
    end
  endtask

  task automatic test_misaligned;
    set_entry(1, 52'h1002, 52'h0, 2'd2, 1'b0);
    run_op(8'b0000_0010, "mis_tetra");
    checks++;
    if (last_obs.exc !== 2'd1) begin
      errors++; $display("FAIL mis_tetra_const: exc=%0d required 1", last_obs.exc);
    end
    set_entry(1, 52'h1002, 52'h0, 2'd1, 1'b0);
    run_op(8'b0000_0010, "mis_wyde");
    checks++;
    if (last_obs.exc !== 2'd0) begin
      errors++; $display("FAIL mis_wyde_const: exc=%0d required 0", last_obs.exc);
    end
    set_entry(3, 52'h1000, 52'h4, 2'd3, 1'b1);
    run_op(8'b0000_1000, "mis_octa");
    set_entry(6, 52'h1003, 52'h0, 2'd0, 1'b0);
    run_op(8'b0100_0000, "mis_byte");
  endtask

  task automatic test_wrap;
    set_entry(0, 52'hF_FFFF_FFFF_FFF8, 52'h10, 2'd3, 1'b0);
    run_op(8'b0000_0001, "wrap");
    checks++;
    if (last_obs.addr !== 52'h8 || last_obs.exc !== 2'd0) begin
      errors++; $display("FAIL wrap_const: addr=%h exc=%0d required 8 0", last_obs.addr, last_obs.exc);
    end
  endtask

  task automatic test_multihot;
    set_entry(5, 52'h500, 52'h5, 2'd0, 1'b1);
    set_entry(7, 52'h700, 52'h7, 2'd3, 1'b0);
    run_op(8'b1010_0000, "multi");
    checks++;
    if (last_obs.qid !== 3'd5 || bus.multi_err !== 1'b1) begin
      errors++; $display("FAIL multi_const: qid=%0d merr=%b required 5 1", last_obs.qid, bus.multi_err);
    end
    set_entry(0, 52'h40, 52'h8, 2'd3, 1'b0);
    run_op(8'b0000_0001, "multi_after");
    checks++;
    if (bus.multi_err !== 1'b1) begin
      errors++; $display("FAIL multi_sticky: merr=%b required 1", bus.multi_err);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] r64;
    logic [AW-1:0] b, im;
    int idx;
    for (int k = 0; k < 8; k++) begin
      idx = $urandom_range(0, N - 1);
      r64 = {$urandom(), $urandom()};
      b = r64[AW-1:0];
      r64 = {$urandom(), $urandom()};
      im = r64[AW-1:0];
      set_entry(idx, b, im, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      run_op(N'(1) << idx, "b2b");
    end
  endtask

`ifdef AGEN_BOUNDS_CHECK_EN
  task automatic test_bounds;
    limit = 52'h2000;
    set_entry(2, 52'h3000, 52'h1, 2'd1, 1'b0);
    run_op(8'b0000_0100, "bounds");
    checks++;
    if (last_obs.exc !== 2'd2) begin
      errors++; $display("FAIL bounds_const: exc=%0d required 2", last_obs.exc);
    end
    set_entry(2, 52'h1FF0, 52'h10, 2'd3, 1'b0);
    run_op(8'b0000_0100, "bounds_edge");
    limit = '1;
  endtask
`endif

  task automatic test_reset_midop;
    bit ok;
    set_entry(3, 52'h3000, 52'h30, 2'd2, 1'b1);
    bus.out_ready = 1'b0;
    issue_op(8'b0000_1000);
    wait_valid(4, "rst_mid", ok);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    checks++;
    if ({bus.out_valid, bus.idle, bus.multi_err, bus.out_addr} !== {1'b0, 1'b1, 1'b0, 52'd0}) begin
      errors++;
      $display("FAIL rst_mid: valid=%b idle=%b merr=%b addr=%h, required 0 1 0 0",
               bus.out_valid, bus.idle, bus.multi_err, bus.out_addr);
    end
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_ghost: out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_ce;
    bit ok;
    set_entry(6, 52'h6000, 52'h66, 2'd1, 1'b0);
    bus.out_ready = 1'b1;
    issue_op(8'b0100_0000);
    ce = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.idle} !== 2'b00) begin
        errors++; $display("FAIL ce_calc%0d: valid,idle=%b required 00", i, {bus.out_valid, bus.idle});
      end
    end
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.idle} !== 2'b10) begin
        errors++; $display("FAIL ce_hold%0d: valid,idle=%b required 10", i, {bus.out_valid, bus.idle});
      end
    end
    ce = 1'b1;
    check_result("ce_result");
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.idle} !== 2'b01) begin
      errors++; $display("FAIL ce_done: valid,idle=%b required 01", {bus.out_valid, bus.idle});
    end
    bus.out_ready = 1'b0;
    issue_op(8'b0100_0000);
    wait_valid(4, "ce_rst", ok);
    ce = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    checks++;
    if ({bus.out_valid, bus.idle} !== 2'b01) begin
      errors++; $display("FAIL ce_rst: valid,idle=%b required 01", {bus.out_valid, bus.idle});
    end
    ce = 1'b1;
    bus.out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    ce  = 1'b1;
`ifdef AGEN_BOUNDS_CHECK_EN
    limit = '1;
`endif
    bus.issue     = '0;
    bus.iq_base   = '0;
    bus.iq_imm    = '0;
    bus.iq_memsz  = '0;
    bus.iq_store  = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_misaligned();
    test_wrap();
    test_multihot();
    test_back_to_back();
`ifdef AGEN_BOUNDS_CHECK_EN
    test_bounds();
`endif
    test_reset_midop();
    test_ce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
